// File: rtl/hazard_scoreboard_if.sv
// Decode/issue/writeback/forwarding bundle between the pipeline and hazard_scoreboard.
// The slave modport is the scoreboard side; the master modport is the pipeline side.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int NUM_FU   = 3,
  parameter int FU_W     = 2,
  parameter int NUM_SRC  = 3,
  parameter int CNT_W    = 32
);
  logic [NUM_SRC-1:0]        src_valid_d;
  logic [NUM_SRC*REG_W-1:0]  src_addr_d;
  logic [NUM_SRC-1:0]        src_fp_d;
  logic                      issue_valid;
  logic [REG_W-1:0]          issue_rd;
  logic                      issue_rd_fp;
  logic [FU_W-1:0]           issue_fu;
  logic [NUM_FU-1:0]         fu_busy;
  logic [NUM_FU-1:0]         wb_valid;
  logic [NUM_FU*REG_W-1:0]   wb_rd;
  logic [NUM_FU-1:0]         wb_fp;
  logic [NUM_SRC*REG_W-1:0]  src_addr_e;
  logic [NUM_SRC-1:0]        src_fp_e;
  logic                      regwrite_m;
  logic                      regwrite_w;
  logic                      rd_fp_m;
  logic                      rd_fp_w;
  logic [REG_W-1:0]          rd_m;
  logic [REG_W-1:0]          rd_w;
  logic                      pcsrc_e;
  logic [NUM_SRC*2-1:0]      forward_sel;
  logic                      stall;
  logic                      flush;
  logic [NUM_REGS-1:0]       pending_int;
  logic [NUM_REGS-1:0]       pending_fp;
  logic                      sb_err;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output src_valid_d, src_addr_d, src_fp_d,
    output issue_valid, issue_rd, issue_rd_fp, issue_fu,
    output fu_busy, wb_valid, wb_rd, wb_fp,
    output src_addr_e, src_fp_e,
    output regwrite_m, regwrite_w, rd_fp_m, rd_fp_w, rd_m, rd_w,
    output pcsrc_e,
    input  forward_sel, stall, flush, pending_int, pending_fp, sb_err, stall_count
  );

  modport slave (
    input  src_valid_d, src_addr_d, src_fp_d,
    input  issue_valid, issue_rd, issue_rd_fp, issue_fu,
    input  fu_busy, wb_valid, wb_rd, wb_fp,
    input  src_addr_e, src_fp_e,
    input  regwrite_m, regwrite_w, rd_fp_m, rd_fp_w, rd_m, rd_w,
    input  pcsrc_e,
    output forward_sel, stall, flush, pending_int, pending_fp, sb_err, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard for multi-cycle FUs (separate int/fp files) with forwarding
// selects, RAW/WAW/structural stall, flush and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int NUM_FU   = 3,
  parameter int FU_W     = 2,
  parameter int NUM_SRC  = 3,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  logic [NUM_REGS-1:0] pending_int_q, pending_fp_q;
  logic [NUM_REGS-1:0] pending_int_next, pending_fp_next;
  logic [FU_W-1:0]     owner_int_q [NUM_REGS];
  logic [FU_W-1:0]     owner_fp_q  [NUM_REGS];
  logic                sb_err_q;
  logic [CNT_W-1:0]    stall_count_q;

  logic [NUM_REGS-1:0] clr_int, clr_fp;
  logic                wb_err;
  logic                raw_hazard, waw_hazard, struct_hazard;
  logic                stall_c;
  logic                set_en;
  logic                dest_is_x0;

  // Writeback decode: only the recorded owner may retire an entry.
  always_comb begin
    logic [REG_W-1:0] rd;
    clr_int = '0;
    clr_fp  = '0;
    wb_err  = 1'b0;
    rd      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      rd = bus.wb_rd[k*REG_W +: REG_W];
      if (bus.wb_valid[k]) begin
        if (bus.wb_fp[k]) begin
          if (pending_fp_q[rd] && (owner_fp_q[rd] == FU_W'(k)))
            clr_fp[rd] = 1'b1;
          else
            wb_err = 1'b1;
        end else begin
          if (pending_int_q[rd] && (owner_int_q[rd] == FU_W'(k)))
            clr_int[rd] = 1'b1;
          else
            wb_err = 1'b1;
        end
      end
    end
  end

  // A source whose entry retires this cycle reads the write-through regfile, so no RAW.
  always_comb begin
    logic [REG_W-1:0] a;
    raw_hazard = 1'b0;
    a          = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      a = bus.src_addr_d[k*REG_W +: REG_W];
      if (bus.src_valid_d[k]) begin
        if (bus.src_fp_d[k])
          raw_hazard = raw_hazard | (pending_fp_q[a] & ~clr_fp[a]);
        else if (a != '0)
          raw_hazard = raw_hazard | (pending_int_q[a] & ~clr_int[a]);
      end
    end
  end

  assign dest_is_x0 = !bus.issue_rd_fp && (bus.issue_rd == '0);

  always_comb begin
    waw_hazard = 1'b0;
    if (bus.issue_valid) begin
      if (bus.issue_rd_fp)
        waw_hazard = pending_fp_q[bus.issue_rd] & ~clr_fp[bus.issue_rd];
      else if (!dest_is_x0)
        waw_hazard = pending_int_q[bus.issue_rd] & ~clr_int[bus.issue_rd];
    end
  end

  // Out-of-range FU indices never match a real unit and count as busy.
  always_comb begin
    logic fu_found;
    fu_found      = 1'b0;
    struct_hazard = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (bus.issue_fu == FU_W'(k)) begin
        fu_found      = 1'b1;
        struct_hazard = bus.fu_busy[k];
      end
    end
    if (!fu_found)
      struct_hazard = 1'b1;
    struct_hazard = struct_hazard & bus.issue_valid;
  end

  assign stall_c = raw_hazard | waw_hazard | struct_hazard;
  assign set_en  = bus.issue_valid & ~stall_c & ~bus.pcsrc_e & ~dest_is_x0;

  // Flush blocks new entries only; completed writebacks still retire, else entries would leak.
  always_comb begin
    pending_int_next = pending_int_q & ~clr_int;
    pending_fp_next  = pending_fp_q  & ~clr_fp;
    if (set_en) begin
      if (bus.issue_rd_fp)
        pending_fp_next[bus.issue_rd] = 1'b1;
      else
        pending_int_next[bus.issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_int_q <= '0;
      pending_fp_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        owner_int_q[r] <= '0;
        owner_fp_q[r]  <= '0;
      end
    end else begin
      pending_int_q <= pending_int_next;
      pending_fp_q  <= pending_fp_next;
      if (set_en) begin
        if (bus.issue_rd_fp)
          owner_fp_q[bus.issue_rd] <= bus.issue_fu;
        else
          owner_int_q[bus.issue_rd] <= bus.issue_fu;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      if (wb_err)
        sb_err_q <= 1'b1;
      if (stall_c && (stall_count_q != '1))
        stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  // Forwarding: M beats W; int x0 never forwards, fp f0 does.
  always_comb begin
    logic [REG_W-1:0] a;
    logic             hit_m, hit_w;
    bus.forward_sel = '0;
    a               = '0;
    hit_m           = 1'b0;
    hit_w           = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      a     = bus.src_addr_e[k*REG_W +: REG_W];
      hit_m = bus.regwrite_m && (bus.rd_fp_m == bus.src_fp_e[k]) && (bus.rd_m == a)
              && !(!bus.rd_fp_m && (bus.rd_m == '0));
      hit_w = bus.regwrite_w && (bus.rd_fp_w == bus.src_fp_e[k]) && (bus.rd_w == a)
              && !(!bus.rd_fp_w && (bus.rd_w == '0));
      if (hit_m)
        bus.forward_sel[k*2 +: 2] = 2'b10;
      else if (hit_w)
        bus.forward_sel[k*2 +: 2] = 2'b01;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush       = bus.pcsrc_e;
  assign bus.pending_int = pending_int_q;
  assign bus.pending_fp  = pending_fp_q;
  assign bus.sb_err      = sb_err_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expected values, a monitor
// process drains the queue against the DUT outputs on each sample event.
module tb_hazard_scoreboard;
  localparam int NR = 32, RW = 5, NF = 3, FW = 2, NS = 3;
  localparam int S_STALL = 0, S_FLUSH = 1, S_FWD = 2, S_PINT = 3, S_PFP = 4,
                 S_ERR = 5, S_CNT = 6, S_CNT4 = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_REGS(NR), .REG_W(RW), .NUM_FU(NF), .FU_W(FW),
                         .NUM_SRC(NS), .CNT_W(32)) bus ();
  hazard_scoreboard_if #(.NUM_REGS(NR), .REG_W(RW), .NUM_FU(NF), .FU_W(FW),
                         .NUM_SRC(NS), .CNT_W(4)) bus4 ();

  hazard_scoreboard #(.NUM_REGS(NR), .REG_W(RW), .NUM_FU(NF), .FU_W(FW),
                      .NUM_SRC(NS), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  hazard_scoreboard #(.NUM_REGS(NR), .REG_W(RW), .NUM_FU(NF), .FU_W(FW),
                      .NUM_SRC(NS), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event sample_ev;

  function automatic logic [63:0] actual(int sig);
    case (sig)
      S_STALL: return 64'(bus.stall);
      S_FLUSH: return 64'(bus.flush);
      S_FWD:   return 64'(bus.forward_sel);
      S_PINT:  return 64'(bus.pending_int);
      S_PFP:   return 64'(bus.pending_fp);
      S_ERR:   return 64'(bus.sb_err);
      S_CNT:   return 64'(bus.stall_count);
      S_CNT4:  return 64'(bus4.stall_count);
      default: return 64'hdead;
    endcase
  endfunction

  always begin
    exp_t        e;
    logic [63:0] act;
    @(sample_ev);
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = actual(e.sig);
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  task automatic ex(input string n, input int s, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic sample();
    -> sample_ev;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wb(input int k, input logic [RW-1:0] rd, input logic fp);
    bus.wb_valid[k]         = 1'b1;
    bus.wb_rd[k*RW +: RW]   = rd;
    bus.wb_fp[k]            = fp;
  endtask

  task automatic clear_wb();
    bus.wb_valid = '0;
    bus.wb_rd    = '0;
    bus.wb_fp    = '0;
  endtask

  task automatic issue(input logic [RW-1:0] rd, input logic fp, input logic [FW-1:0] fu);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_rd_fp = fp;
    bus.issue_fu    = fu;
  endtask

  task automatic clear_inputs();
    bus.src_valid_d = '0; bus.src_addr_d = '0; bus.src_fp_d = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_rd_fp = 1'b0; bus.issue_fu = '0;
    bus.fu_busy = '0; bus.wb_valid = '0; bus.wb_rd = '0; bus.wb_fp = '0;
    bus.src_addr_e = '0; bus.src_fp_e = '0;
    bus.regwrite_m = 1'b0; bus.regwrite_w = 1'b0; bus.rd_fp_m = 1'b0; bus.rd_fp_w = 1'b0;
    bus.rd_m = '0; bus.rd_w = '0; bus.pcsrc_e = 1'b0;
    bus4.src_valid_d = '0; bus4.src_addr_d = '0; bus4.src_fp_d = '0;
    bus4.issue_valid = 1'b0; bus4.issue_rd = '0; bus4.issue_rd_fp = 1'b0; bus4.issue_fu = '0;
    bus4.fu_busy = '0; bus4.wb_valid = '0; bus4.wb_rd = '0; bus4.wb_fp = '0;
    bus4.src_addr_e = '0; bus4.src_fp_e = '0;
    bus4.regwrite_m = 1'b0; bus4.regwrite_w = 1'b0; bus4.rd_fp_m = 1'b0; bus4.rd_fp_w = 1'b0;
    bus4.rd_m = '0; bus4.rd_w = '0; bus4.pcsrc_e = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    ex("rst_pint", S_PINT, 0); ex("rst_pfp", S_PFP, 0); ex("rst_err", S_ERR, 0);
    ex("rst_cnt", S_CNT, 0); ex("rst_stall", S_STALL, 0); ex("rst_flush", S_FLUSH, 0);
    ex("rst_fwd", S_FWD, 0);
    sample();
    rst_n = 1'b1;

    // RAW on FP register f3 owned by FU1
    issue(5'd3, 1'b1, 2'd1);
    ex("issue_f3_stall", S_STALL, 0);
    sample();
    step();
    bus.issue_valid = 1'b0;
    bus.src_valid_d = 3'b001; bus.src_addr_d = 15'd3; bus.src_fp_d = 3'b001;
    ex("pend_f3", S_PFP, 64'h8); ex("raw_f3_stall", S_STALL, 1);
    sample();
    step();
    ex("raw_f3_stall_hold", S_STALL, 1); ex("pend_f3_hold", S_PFP, 64'h8);
    sample();
    set_wb(1, 5'd3, 1'b1);
    ex("raw_f3_wb_bypass", S_STALL, 0); ex("pend_f3_wb_cycle", S_PFP, 64'h8);
    sample();
    step();
    clear_wb();
    bus.src_valid_d = '0;
    ex("pend_f3_cleared", S_PFP, 0); ex("cnt_after_raw", S_CNT, 1); ex("err_clean", S_ERR, 0);
    sample();

    // File separation and x0
    issue(5'd3, 1'b0, 2'd0);
    step();
    bus.issue_valid = 1'b0;
    bus.src_valid_d = 3'b001; bus.src_addr_d = 15'd3; bus.src_fp_d = 3'b001;
    ex("pend_x3", S_PINT, 64'h8); ex("f3_read_x3_pending", S_STALL, 0);
    sample();
    bus.src_valid_d = '0;
    issue(5'd0, 1'b0, 2'd2);
    step();
    bus.issue_valid = 1'b0;
    ex("x0_not_pending", S_PINT, 64'h8);
    sample();
    bus.regwrite_m = 1'b1; bus.rd_m = 5'd0; bus.rd_fp_m = 1'b0;
    bus.src_addr_e = '0; bus.src_fp_e = '0;
    ex("fwd_x0_none", S_FWD, 0);
    sample();
    bus.rd_fp_m = 1'b1; bus.src_fp_e = 3'b001;
    ex("fwd_f0_m", S_FWD, 64'h2);
    sample();
    bus.src_fp_e = 3'b000;
    ex("fwd_file_mismatch", S_FWD, 0);
    sample();

    // Forward priority M over W
    bus.regwrite_m = 1'b1; bus.rd_m = 5'd7; bus.rd_fp_m = 1'b0;
    bus.regwrite_w = 1'b1; bus.rd_w = 5'd7; bus.rd_fp_w = 1'b0;
    bus.src_addr_e = 15'd7; bus.src_fp_e = '0;
    ex("fwd_m_priority", S_FWD, 64'h2);
    sample();
    if (bus.forward_sel[1:0] !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_m_priority_direct: got %b", bus.forward_sel[1:0]);
    end
    n_tests++;
    bus.regwrite_m = 1'b0;
    bus.src_addr_e = {5'd0, 5'd7, 5'd7};
    ex("fwd_w_only", S_FWD, 64'h5);
    sample();
    bus.rd_fp_w = 1'b1; bus.src_fp_e = 3'b010;
    ex("fwd_w_fp_src1", S_FWD, 64'h4);
    sample();
    bus.regwrite_w = 1'b0; bus.rd_w = '0; bus.rd_fp_w = 1'b0; bus.rd_m = '0; bus.rd_fp_m = 1'b0;
    bus.src_addr_e = '0; bus.src_fp_e = '0;

    // WAW, structural, flush
    issue(5'd9, 1'b0, 2'd2);
    step();
    issue(5'd9, 1'b0, 2'd0);
    ex("waw_stall", S_STALL, 1); ex("pend_x9", S_PINT, 64'h208);
    sample();
    step();
    issue(5'd10, 1'b0, 2'd1);
    bus.fu_busy = 3'b010; bus.pcsrc_e = 1'b1;
    ex("struct_stall", S_STALL, 1); ex("flush_on", S_FLUSH, 1);
    sample();
    if (bus.stall !== 1'b1 || bus.flush !== 1'b1) begin
      n_fail++;
      $display("FAIL struct_flush_direct: stall=%b flush=%b", bus.stall, bus.flush);
    end
    n_tests++;
    step();
    ex("struct_no_set", S_PINT, 64'h208);
    sample();
    bus.fu_busy = '0;
    ex("flush_no_stall", S_STALL, 0); ex("flush_still", S_FLUSH, 1);
    sample();
    step();
    bus.pcsrc_e = 1'b0;
    ex("flush_no_set", S_PINT, 64'h208); ex("flush_off", S_FLUSH, 0);
    sample();
    issue(5'd11, 1'b0, 2'd3);
    ex("bad_fu_stall", S_STALL, 1);
    sample();
    step();
    bus.issue_valid = 1'b0;
    ex("bad_fu_no_set", S_PINT, 64'h208); ex("cnt_after_struct", S_CNT, 4);
    sample();

    // Wrong-owner writeback and sticky error
    issue(5'd4, 1'b0, 2'd0);
    step();
    bus.issue_valid = 1'b0;
    set_wb(2, 5'd4, 1'b0);
    ex("pend_x4", S_PINT, 64'h218); ex("err_not_yet", S_ERR, 0);
    sample();
    step();
    clear_wb();
    ex("err_set", S_ERR, 1); ex("x4_kept", S_PINT, 64'h218);
    sample();
    step();
    ex("err_sticky", S_ERR, 1);
    sample();
    if (bus.sb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky_direct: got %b", bus.sb_err);
    end
    n_tests++;

    // Set and clear of x9 in one cycle: set wins with new owner FU1
    issue(5'd9, 1'b0, 2'd1);
    set_wb(2, 5'd9, 1'b0);
    ex("set_clr_no_stall", S_STALL, 0);
    sample();
    step();
    bus.issue_valid = 1'b0;
    clear_wb();
    ex("set_wins", S_PINT, 64'h218);
    sample();
    set_wb(1, 5'd9, 1'b0);
    step();
    clear_wb();
    ex("new_owner_clears", S_PINT, 64'h018);
    sample();
    set_wb(0, 5'd4, 1'b0);
    set_wb(1, 5'd4, 1'b0);
    step();
    clear_wb();
    ex("multi_wb_owner_clears", S_PINT, 64'h008);
    sample();
    set_wb(0, 5'd3, 1'b0);
    step();
    clear_wb();
    ex("x3_cleared", S_PINT, 0);
    sample();

    // Asynchronous reset mid-operation
    issue(5'd5, 1'b0, 2'd0);
    step();
    issue(5'd2, 1'b1, 2'd1);
    step();
    bus.issue_valid = 1'b0;
    ex("pre_rst_pint", S_PINT, 64'h20); ex("pre_rst_pfp", S_PFP, 64'h4);
    ex("pre_rst_cnt", S_CNT, 4);
    sample();
    #1;
    rst_n = 1'b0;
    #1;
    ex("async_rst_pint", S_PINT, 0); ex("async_rst_pfp", S_PFP, 0);
    ex("async_rst_cnt", S_CNT, 0); ex("async_rst_err", S_ERR, 0);
    sample();
    if (bus.pending_int !== '0 || bus.pending_fp !== '0 || bus.stall_count !== '0) begin
      n_fail++;
      $display("FAIL async_rst_direct: pint=0x%0h pfp=0x%0h cnt=%0d",
               bus.pending_int, bus.pending_fp, bus.stall_count);
    end
    n_tests++;
    step();
    rst_n = 1'b1;

    // Saturating 4-bit counter
    bus4.issue_valid = 1'b1;
    bus4.issue_fu    = 2'd3;
    repeat (14) step();
    ex("cnt4_14", S_CNT4, 14);
    sample();
    step();
    ex("cnt4_15", S_CNT4, 15);
    sample();
    repeat (5) step();
    ex("cnt4_saturated", S_CNT4, 15);
    sample();
    if (bus4.stall_count !== 4'd15) begin
      n_fail++;
      $display("FAIL cnt4_saturated_direct: got %0d", bus4.stall_count);
    end
    n_tests++;
    bus4.issue_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
